// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the 7-segment scan receiver.
package seg_scan_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  // Active-low segment patterns, bit6 = a ... bit0 = g
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

  function automatic logic one_cold(input logic [NUM_DIGITS-1:0] an_n);
    return ($countones(~an_n) == 1);
  endfunction

  function automatic logic [1:0] cold_idx(input logic [NUM_DIGITS-1:0] an_n);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!an_n[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low 7-segment to hex decoder with blank detection.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] value,
  output logic       match,
  output logic       blank
);

  always_comb begin
    value = '0;
    match = 1'b1;
    blank = 1'b0;
    case (seg_n)
      SEG_0: value = 4'h0;
      SEG_1: value = 4'h1;
      SEG_2: value = 4'h2;
      SEG_3: value = 4'h3;
      SEG_4: value = 4'h4;
      SEG_5: value = 4'h5;
      SEG_6: value = 4'h6;
      SEG_7: value = 4'h7;
      SEG_8: value = 4'h8;
      SEG_9: value = 4'h9;
      SEG_A: value = 4'hA;
      SEG_B: value = 4'hB;
      SEG_C: value = 4'hC;
      SEG_D: value = 4'hD;
      SEG_E: value = 4'hE;
      SEG_F: value = 4'hF;
      SEG_BLANK: begin
        match = 1'b0;
        blank = 1'b1;
      end
      default: match = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_rx.sv
// Receives a multiplexed 7-segment display scan and recovers per-digit hex values.
// Define SEG_SCAN_RX_ERRCNT_EN to add the saturating err_cnt output.
module seg_scan_rx
  import seg_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] digit_val,
  output logic [3:0]  digit_ok,
  output logic        upd_valid,
  output logic [1:0]  upd_idx,
  output logic [3:0]  upd_val,
  output logic        err
`ifdef SEG_SCAN_RX_ERRCNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0] r_seg_s1, r_seg_s2, r_seg_p;
  logic [3:0] r_an_s1, r_an_s2, r_an_p;
  state_t     r_state;
  logic [7:0] r_cnt;

  logic       w_change;
  logic       w_onecold;
  logic [1:0] w_idx;
  logic       w_capture;
  logic [3:0] w_dec_val;
  logic       w_dec_match;
  logic       w_dec_blank;

  seg7_decode u_dec (
    .seg_n (r_seg_s2),
    .value (w_dec_val),
    .match (w_dec_match),
    .blank (w_dec_blank)
  );

  assign w_change  = ({r_seg_s2, r_an_s2} != {r_seg_p, r_an_p});
  assign w_onecold = one_cold(r_an_s2);
  assign w_idx     = cold_idx(r_an_s2);
  // The counter has already seen STABLE_CYCLES-1 stable samples; this one completes the episode.
  assign w_capture = (r_state == ST_SETTLE) && !w_change && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_seg_p  <= '1;
      r_an_s1  <= '1;
      r_an_s2  <= '1;
      r_an_p   <= '1;
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
    end else begin
      r_seg_s1 <= seg_n;
      r_seg_s2 <= r_seg_s1;
      r_an_s1  <= an_n;
      r_an_s2  <= r_an_s1;
      r_seg_p  <= r_seg_s2;
      r_an_p   <= r_an_s2;
      if (w_change) begin
        r_cnt   <= '0;
        r_state <= w_onecold ? ST_SETTLE : ST_IDLE;
      end else if (w_capture) begin
        r_state <= ST_HELD;
      end else if (r_state == ST_SETTLE) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_val <= '0;
      digit_ok  <= '0;
      upd_valid <= 1'b0;
      upd_idx   <= '0;
      upd_val   <= '0;
      err       <= 1'b0;
    end else begin
      upd_valid <= 1'b0;
      err       <= 1'b0;
      if (w_capture) begin
        if (w_dec_match) begin
          digit_val[4*w_idx +: 4] <= w_dec_val;
          digit_ok[w_idx]         <= 1'b1;
          upd_valid               <= 1'b1;
          upd_idx                 <= w_idx;
          upd_val                 <= w_dec_val;
        end else begin
          digit_ok[w_idx] <= 1'b0;
          err             <= !w_dec_blank;
        end
      end
    end
  end

`ifdef SEG_SCAN_RX_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/seg_scan_rx.md
SEG_SCAN_RX -- requirements
Module: seg_scan_rx

Interface
- REQ-001 SHALL provide parameter STABLE_CYCLES, default 4, giving the number of consecutive identical samples (range 2..255) required before a capture.
- REQ-002 SHALL provide port clk, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-003 SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-004 SHALL provide port seg_n, input, 7 bits: active-low segments; bit6 = a through bit0 = g.
- REQ-005 SHALL provide port an_n, input, 4 bits: active-low digit selects; exactly one bit low selects a digit.
- REQ-006 SHALL provide port digit_val, output, 16 bits: last decoded value per digit; nibble i belongs to digit i.
- REQ-007 SHALL provide port digit_ok, output, 4 bits: bit i is 1 when nibble i holds a valid decode.
- REQ-008 SHALL provide ports upd_valid (output, 1 bit), upd_idx (output, 2 bits) and upd_val (output, 4 bits): a one-cycle update strobe with the captured digit index and value.
- REQ-009 SHALL provide port err, output, 1 bit: one-cycle pulse when an undecodable pattern is captured.

Function
- REQ-010 SHALL pass seg_n and an_n through a 2-flop synchronizer; all following logic uses the second-stage sample S.
- REQ-011 SHALL register the previous sample P and treat S differing from P in any bit as a change.
- REQ-012 SHALL implement FSM states IDLE, SETTLE and HELD.
  - IDLE: an_n not one-cold (all ones or multiple lows).
  - SETTLE: counting stability.
  - HELD: captured, waiting for a change.
- REQ-013 SHALL transition from any state to IDLE on a change when S.an_n is not one-cold; no capture, no err.
- REQ-014 SHALL transition from any state to SETTLE with counter=0 on a change when S.an_n is one-cold.
- REQ-015 SHALL, in SETTLE with no change, increment the counter; when it reaches STABLE_CYCLES-1 it SHALL capture and enter HELD.
- REQ-016 SHALL perform at most one capture per stable episode; HELD SHALL ignore further identical samples.
- REQ-017 SHALL, on capture of a valid pattern, decode S.seg_n against the 16 hex patterns:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - Write the nibble, set digit_ok[i], and pulse upd_valid with upd_idx=i and upd_val=value.
- REQ-018 SHALL, on capture of a non-matching pattern, clear digit_ok[i], hold nibble i, pulse err, and keep upd_valid low.
- REQ-019 SHALL, on capture of the blank pattern 1111111, clear digit_ok[i] without err.
- REQ-020 SHALL produce registered outputs; the update appears on the first edge after the capture decision, giving a latency of STABLE_CYCLES+3 rising edges from the input change.

Reset
- REQ-021 SHALL, while rst is high, force digit_val=0, digit_ok=0, upd_valid=0, upd_idx=0, upd_val=0, err=0, state=IDLE, counter=0, and the sync/previous registers to all ones.
- REQ-022 SHALL discard any in-progress episode on reset assertion mid-SETTLE, with no capture after release until a fresh stable episode completes.

Configuration
- REQ-023 SHALL provide macro SEG_SCAN_RX_ERRCNT_EN. When it is defined:
  - Port err_cnt, output, 8 bits, counts err pulses, saturates at 255, and resets to 0.
  - When it is undefined, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
- REQ-024 SHALL place the 16 segment-pattern constants, SEG_BLANK, the FSM state type and the digit-count constant in package seg_scan_pkg.
- REQ-025 SHALL implement decode in combinational sub-module seg7_decode (seg_n in; value, match and blank out).

Verification
- REQ-026 SHALL test an_n=1101, seg_n=0010010 held 10 cycles (STABLE_CYCLES=4) -> one upd_valid, 7 edges after the change, upd_idx=1, upd_val=2, digit_val[7:4]=2, digit_ok=0010.
- REQ-027 SHALL test a 4-digit scan with 8-cycle dwell showing 1,A,C,F on digits 0..3 -> digit_val=16'hFCA1, digit_ok=1111, four upd_valid pulses.
- REQ-028 SHALL test seg_n=1010101 on digit 2 after a valid value -> err one cycle, digit_ok[2]=0, nibble 2 unchanged, err_cnt=1 with the macro.
- REQ-029 SHALL test a glitch: a pattern held 2 cycles, then changed -> no capture; only the later stable pattern updates.
- REQ-030 SHALL test an_n=0011 or 1111 held 20 cycles -> no upd_valid, no err.
- REQ-031 SHALL test rst pulsed mid-SETTLE on digit 3 -> all outputs 0, no update until STABLE_CYCLES+3 edges after a new change.
